// File: rtl/frame_sync_pkg.sv
`default_nettype none
// ============================================================================
// Module      : frame_sync_pkg
// Description : Shared types and width helpers for the serial frame
//               synchronisation controller.
//               - state_t   : controller state encoding (HUNT/VERIFY/LOCKED)
//               - pos_w()   : width of the in-frame position counter
//               - cnt_w()   : width of a counter that must hold 0..limit
// Revision    : 1.0 - initial release
// ============================================================================
package frame_sync_pkg;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Position counter covers FRAME_LEN payload slots plus SYNC_W sync slots.
    function automatic int pos_w(input int frame_len, input int sync_w);
        return $clog2(frame_len + sync_w);
    endfunction

    // A counter that has to reach 'limit' inclusive; never narrower than 1 bit.
    function automatic int cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage : frame_sync_pkg
`default_nettype wire

// File: rtl/sync_matcher.sv
`default_nettype none
// ============================================================================
// Module      : sync_matcher
// Description : Sliding sync-word detector on a 1-bit serial stream.
//               match is combinational on the bit currently offered, so the
//               controller can act on it at the same clock edge that
//               accepts the bit.
// Ports       : clk      - clock
//               rst      - synchronous active-high reset (clears history)
//               in_valid - qualifies in; history only shifts when set
//               in       - serial data bit
//               match    - 1 when the last SYNC_W bits (including in)
//                          equal SYNC_PATTERN
// Revision    : 1.0 - initial release
// ============================================================================
module sync_matcher
    import frame_sync_pkg::*;
#(
    parameter int                SYNC_W       = 4,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011
) (
    input  logic clk,
    input  logic rst,
    input  logic in_valid,
    input  logic in,
    output logic match
);

    // Only the newest SYNC_W-1 bits of the shift register are ever compared
    // again; the oldest bit would be shifted out without being read, so the
    // history holds SYNC_W-1 bits and the live bit completes the window.
    logic [SYNC_W-2:0] r_hist;
    logic [SYNC_W-1:0] w_window;

    assign w_window = {r_hist, in};
    assign match    = (w_window == SYNC_PATTERN);

    // Runs in every controller state so overlapping patterns are never lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
        end else if (in_valid) begin
            r_hist <= w_window[SYNC_W-2:0];
        end
    end

endmodule : sync_matcher
`default_nettype wire

// File: rtl/frame_sync_controller.sv
`default_nettype none
// ============================================================================
// Module      : frame_sync_controller
// Description : Serial frame-synchronisation controller. Hunts the input
//               stream for a sync word, confirms it over CONFIRM frames,
//               then delivers payload bits with frame markers. Isolated sync
//               errors are flywheeled; MISS_MAX consecutive misses drop lock.
// Ports       : clk           - clock, rising edge
//               rst           - synchronous active-high reset
//               in_valid      - qualifies in; idle cycles change no state
//               in            - serial data bit
//               locked        - 1 while in LOCKED
//               payload_valid - 1-cycle pulse per delivered payload bit
//               payload_bit   - payload data, held when payload_valid=0
//               frame_start   - marks payload bit 0 of each frame
//               sync_lost     - 1-cycle pulse when LOCKED falls to HUNT
//               state_o       - debug view of the state (HUNT/VERIFY/LOCKED)
// Revision    : 1.0 - initial release
// ============================================================================
module frame_sync_controller
    import frame_sync_pkg::*;
#(
    parameter int                SYNC_W       = 4,
    parameter logic [SYNC_W-1:0] SYNC_PATTERN = 4'b1011,
    parameter int                FRAME_LEN    = 8,
    parameter int                CONFIRM      = 2,
    parameter int                MISS_MAX     = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic       in,
    output logic       locked,
    output logic       payload_valid,
    output logic       payload_bit,
    output logic       frame_start,
    output logic       sync_lost,
    output logic [1:0] state_o
);

    localparam int POS_W  = pos_w(FRAME_LEN, SYNC_W);
    localparam int GOOD_W = cnt_w(CONFIRM);
    localparam int MISS_W = cnt_w(MISS_MAX);

    // Position of the last sync bit, where the sync word is judged.
    localparam logic [POS_W-1:0]  C_POS_CHECK = POS_W'(FRAME_LEN + SYNC_W - 1);
    // Positions below this value are payload slots.
    localparam logic [POS_W-1:0]  C_POS_PL_END = POS_W'(FRAME_LEN);
    localparam logic [GOOD_W-1:0] C_GOOD_LIM   = GOOD_W'(CONFIRM);
    localparam logic [MISS_W-1:0] C_MISS_LIM   = MISS_W'(MISS_MAX);

    // ------------------------------------------------------------------
    // Sync word detector
    // ------------------------------------------------------------------
    logic w_match;

    sync_matcher #(
        .SYNC_W       (SYNC_W),
        .SYNC_PATTERN (SYNC_PATTERN)
    ) u_sync_matcher (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in       (in),
        .match    (w_match)
    );

    // ------------------------------------------------------------------
    // State, counters and output registers
    // ------------------------------------------------------------------
    state_t            r_state,  w_state_nxt;
    logic [POS_W-1:0]  r_pos,    w_pos_nxt;
    logic [GOOD_W-1:0] r_good,   w_good_nxt;
    logic [MISS_W-1:0] r_miss,   w_miss_nxt;
    logic              r_locked, w_locked_nxt;
    logic              r_pv,     w_pv_nxt;
    logic              r_pbit,   w_pbit_nxt;
    logic              r_fs,     w_fs_nxt;
    logic              r_lost,   w_lost_nxt;

    logic              w_at_check;
    logic [POS_W-1:0]  w_pos_adv;
    logic [GOOD_W-1:0] w_good_inc;
    logic [MISS_W-1:0] w_miss_inc;

    assign w_at_check = (r_pos == C_POS_CHECK);
    assign w_pos_adv  = w_at_check ? '0 : (r_pos + 1'b1);
    assign w_good_inc = r_good + 1'b1;
    assign w_miss_inc = r_miss + 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= HUNT;
            r_pos    <= '0;
            r_good   <= '0;
            r_miss   <= '0;
            r_locked <= 1'b0;
            r_pv     <= 1'b0;
            r_pbit   <= 1'b0;
            r_fs     <= 1'b0;
            r_lost   <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_pos    <= w_pos_nxt;
            r_good   <= w_good_nxt;
            r_miss   <= w_miss_nxt;
            r_locked <= w_locked_nxt;
            r_pv     <= w_pv_nxt;
            r_pbit   <= w_pbit_nxt;
            r_fs     <= w_fs_nxt;
            r_lost   <= w_lost_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_pos_nxt   = r_pos;
        w_good_nxt  = r_good;
        w_miss_nxt  = r_miss;
        w_pv_nxt    = 1'b0;
        w_pbit_nxt  = r_pbit;
        w_fs_nxt    = 1'b0;
        w_lost_nxt  = 1'b0;

        if (in_valid) begin
            unique case (r_state)
                HUNT: begin
                    // The hit bit is the last sync bit, so the next bit is
                    // payload position 0.
                    if (w_match) begin
                        w_pos_nxt  = '0;
                        w_good_nxt = GOOD_W'(1);
                        if (CONFIRM == 1) begin
                            w_state_nxt = LOCKED;
                            w_miss_nxt  = '0;
                        end else begin
                            w_state_nxt = VERIFY;
                        end
                    end
                end

                VERIFY: begin
                    w_pos_nxt = w_pos_adv;
                    if (w_at_check) begin
                        if (w_match) begin
                            w_good_nxt = w_good_inc;
                            if (w_good_inc == C_GOOD_LIM) begin
                                w_state_nxt = LOCKED;
                                w_miss_nxt  = '0;
                            end
                        end else begin
                            // The failing bit is not rescanned as a hunt hit;
                            // HUNT starts looking from the next bit.
                            w_state_nxt = HUNT;
                        end
                    end
                end

                LOCKED: begin
                    w_pos_nxt = w_pos_adv;
                    if (r_pos < C_POS_PL_END) begin
                        w_pv_nxt   = 1'b1;
                        w_pbit_nxt = in;
                        w_fs_nxt   = (r_pos == '0);
                    end
                    if (w_at_check) begin
                        if (w_match) begin
                            w_miss_nxt = '0;
                        end else if (w_miss_inc == C_MISS_LIM) begin
                            w_state_nxt = HUNT;
                            w_miss_nxt  = '0;
                            w_lost_nxt  = 1'b1;
                        end else begin
                            // Flywheel: keep framing on the expected position.
                            w_miss_nxt = w_miss_inc;
                        end
                    end
                end

                default: begin
                    w_state_nxt = HUNT;
                end
            endcase
        end

        // locked tracks the state the controller is about to enter so it
        // rises and falls on the same edge as the state register.
        w_locked_nxt = (w_state_nxt == LOCKED);
    end

    assign locked        = r_locked;
    assign payload_valid = r_pv;
    assign payload_bit   = r_pbit;
    assign frame_start   = r_fs;
    assign sync_lost     = r_lost;
    assign state_o       = r_state;

endmodule : frame_sync_controller
`default_nettype wire

// File: tb/tb_frame_sync_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_frame_sync_controller
// Description : Self-checking bench for frame_sync_controller (defaults:
//               sync 1011, 8-bit frames, CONFIRM=2, MISS_MAX=2). Expected
//               payload bits are queued as they are driven and compared when
//               the DUT pulses payload_valid.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_frame_sync_controller;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in = 1'b0;
    logic       locked;
    logic       payload_valid;
    logic       payload_bit;
    logic       frame_start;
    logic       sync_lost;
    logic [1:0] state_o;

    frame_sync_controller #(
        .SYNC_W       (4),
        .SYNC_PATTERN (4'b1011),
        .FRAME_LEN    (8),
        .CONFIRM      (2),
        .MISS_MAX     (2)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in            (in),
        .locked        (locked),
        .payload_valid (payload_valid),
        .payload_bit   (payload_bit),
        .frame_start   (frame_start),
        .sync_lost     (sync_lost),
        .state_o       (state_o)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;
    int n_lost   = 0;

    // Expected payload entries: {frame_start, payload_bit}
    logic [1:0] exp_q[$];

    logic [6:0] outs;
    assign outs = {locked, payload_valid, payload_bit, frame_start, sync_lost, state_o};

    task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Scoreboard monitor, sampled mid-cycle away from the active edge.
    always @(negedge clk) begin
        if (sync_lost === 1'b1) n_lost++;
        if (payload_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_payload", {14'd0, frame_start, payload_bit}, 16'hFFFF);
            end else begin
                check_eq("payload", {14'd0, frame_start, payload_bit}, {14'd0, exp_q.pop_front()});
            end
        end else if (frame_start === 1'b1) begin
            check_eq("frame_start_alone", 16'd1, 16'd0);
        end
    end

    // Drive one accepted bit; pl/fs state whether it must emerge as payload.
    task automatic send(input logic b, input bit pl, input bit fs);
        in_valid = 1'b1;
        in       = b;
        if (pl) exp_q.push_back({fs, b});
        @(posedge clk);
        #1;
    endtask

    task automatic send_seq(input logic [15:0] v, input int n, input bit pl, input bit fs_first);
        for (int i = n - 1; i >= 0; i--) begin
            send(v[i], pl, pl && fs_first && (i == n - 1));
        end
    endtask

    task automatic idle_check(input int n);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b0;
            in       = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check_eq("idle_no_pulse", {14'd0, payload_valid, frame_start}, 16'd0);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in       = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
            check_eq("reset_outs", {9'd0, outs}, 16'd0);
        end
        rst = 1'b0;
    endtask

    // Sync, A5 frame (not delivered), sync -> lock, delivered frame, sync.
    task automatic lock_seq();
        send_seq(16'b1011, 4, 1'b0, 1'b0);
        check_eq("verify_after_hit", {14'd0, state_o}, 16'd1);
        check_eq("no_lock_after_hit", {15'd0, locked}, 16'd0);
        send_seq(16'hA5, 8, 1'b0, 1'b0);
        send_seq(16'b101, 3, 1'b0, 1'b0);
        check_eq("no_lock_early", {15'd0, locked}, 16'd0);
        send(1'b1, 1'b0, 1'b0);
        check_eq("locked_after_confirm", {15'd0, locked}, 16'd1);
        check_eq("state_locked", {14'd0, state_o}, 16'd2);
        send_seq(16'b00111100, 8, 1'b1, 1'b1);
        send_seq(16'b1011, 4, 1'b0, 1'b0);
        check_eq("still_locked", {15'd0, locked}, 16'd1);
    endtask

    initial begin
        // Reset with random input activity
        reset_dut();

        // Acquisition and first delivered frame
        lock_seq();

        // in_valid gaps mid-payload freeze position
        send_seq(16'b1010, 4, 1'b1, 1'b1);
        idle_check(3);
        send_seq(16'b0110, 4, 1'b1, 1'b0);
        send_seq(16'b1011, 4, 1'b0, 1'b0);
        check_eq("locked_after_gap", {15'd0, locked}, 16'd1);
        check_eq("no_loss_after_gap", 16'(n_lost), 16'd0);

        // Flywheel over one miss, recovery, then two consecutive misses
        send_seq(16'hC3, 8, 1'b1, 1'b1);
        send_seq(16'b0000, 4, 1'b0, 1'b0);
        check_eq("flywheel_locked", {15'd0, locked}, 16'd1);
        check_eq("flywheel_state", {14'd0, state_o}, 16'd2);
        send_seq(16'h5A, 8, 1'b1, 1'b1);
        send_seq(16'b1011, 4, 1'b0, 1'b0);
        send_seq(16'h0F, 8, 1'b1, 1'b1);
        send_seq(16'b0000, 4, 1'b0, 1'b0);
        check_eq("one_miss_locked", {15'd0, locked}, 16'd1);
        send_seq(16'hF0, 8, 1'b1, 1'b1);
        send_seq(16'b000, 3, 1'b0, 1'b0);
        check_eq("locked_before_2nd_miss", {15'd0, locked}, 16'd1);
        send(1'b0, 1'b0, 1'b0);
        check_eq("lost_pulse", {15'd0, sync_lost}, 16'd1);
        check_eq("lost_unlocked", {15'd0, locked}, 16'd0);
        check_eq("lost_state_hunt", {14'd0, state_o}, 16'd0);
        idle_check(1);
        check_eq("lost_pulse_ends", {15'd0, sync_lost}, 16'd0);
        check_eq("lost_count", 16'(n_lost), 16'd1);

        // Overlapping hunt hit, then a corrupted sync in VERIFY
        reset_dut();
        send_seq(16'b101, 3, 1'b0, 1'b0);
        check_eq("hunt_before_hit", {14'd0, state_o}, 16'd0);
        send(1'b1, 1'b0, 1'b0);
        check_eq("hunt_hit_bit4", {14'd0, state_o}, 16'd1);
        send_seq(16'b011, 3, 1'b0, 1'b0);
        send_seq(16'b00000, 5, 1'b0, 1'b0);
        send_seq(16'b111, 3, 1'b0, 1'b0);
        check_eq("verify_until_check", {14'd0, state_o}, 16'd1);
        send(1'b1, 1'b0, 1'b0);
        check_eq("bad_sync_to_hunt", {14'd0, state_o}, 16'd0);
        check_eq("bad_sync_unlocked", {15'd0, locked}, 16'd0);

        // Reset while delivering payload, then relock
        reset_dut();
        lock_seq();
        send_seq(16'b110, 3, 1'b1, 1'b1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in       = 1'b1;
        @(posedge clk);
        #1;
        check_eq("midframe_reset_outs", {9'd0, outs}, 16'd0);
        rst = 1'b0;
        lock_seq();

        @(negedge clk);
        check_eq("scoreboard_empty", 16'(exp_q.size()), 16'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule : tb_frame_sync_controller
`default_nettype wire

// File: doc/frame_sync_controller.md
Name: frame_sync_controller

Overview:
- Serial frame-synchronisation controller.
- Hunts a 1-bit input stream for a sync word, confirms it over consecutive frames, then declares lock and delivers payload bits with frame markers.
- Flywheels through isolated sync errors; drops lock after repeated misses.
- Sits between the serial line receiver and downstream frame/deframer logic.

Parameters:
- SYNC_W, 4, sync word width in bits (>=2).
- SYNC_PATTERN, 4'b1011, sync word, MSB received first. Must not be all zeros.
- FRAME_LEN, 8, payload bits between consecutive sync words (>=1).
- CONFIRM, 2, consecutive good sync words required to lock; the initial hunt hit counts as one (>=1).
- MISS_MAX, 2, consecutive missed sync words in LOCKED that force re-hunt (>=1).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  qualifies in. Cycles with in_valid=0 change no state and no counters.
- in  in  1  serial data bit.
- locked  out  1  registered; 1 while in LOCKED.
- payload_valid  out  1  registered; 1-cycle pulse per delivered payload bit.
- payload_bit  out  1  registered payload data. Holds its last value when payload_valid=0.
- frame_start  out  1  registered; pulses together with payload_valid on payload bit 0 of each frame.
- sync_lost  out  1  registered; 1-cycle pulse when LOCKED exits to HUNT.
- state_o  out  2  current state for debug: HUNT=0, VERIFY=1, LOCKED=2.

Behaviour:
- Reset (sync, rst=1 at a rising edge):
  - state=HUNT; shift register, pos, good_cnt and miss_cnt cleared.
  - All outputs 0 on the following cycle. This applies even mid-frame or while LOCKED.
- Shift register sr (SYNC_W bits):
  - On an accepted bit, sr <= {sr[SYNC_W-2:0], in}.
  - match = ({sr[SYNC_W-2:0], in} == SYNC_PATTERN), evaluated combinationally on the accepted bit.
  - sr runs continuously in every state and is never cleared except by rst.
- Position counter pos, range 0..FRAME_LEN+SYNC_W-1:
  - 0..FRAME_LEN-1 are payload positions; the rest are sync positions.
  - The sync check happens at pos = FRAME_LEN+SYNC_W-1, the last sync bit.
  - pos increments per accepted bit and wraps to 0 after the check.
- HUNT:
  - Each accepted bit with match=1 sets pos=0 and good_cnt=1.
  - Next state is LOCKED if CONFIRM==1, else VERIFY.
  - Overlapping patterns are found, because sr is not cleared.
- VERIFY:
  - Payload bits are counted but not delivered.
  - At the sync check with match=1: good_cnt++. When good_cnt reaches CONFIRM, go to LOCKED with miss_cnt=0.
  - At the sync check with match=0: go to HUNT. The current bit is not rescanned as a new hunt hit.
- LOCKED:
  - Each payload-position bit produces payload_valid=1 and payload_bit=in on the next cycle. Latency is 1 cycle.
  - frame_start=1 with pos=0.
  - The first delivered frame is the one after the confirming sync.
  - At the sync check with match=1: miss_cnt=0.
  - At the sync check with match=0: miss_cnt++. When it reaches MISS_MAX, go to HUNT and pulse sync_lost with locked=0 in the same next cycle. Otherwise stay LOCKED with pos wrapping normally (flywheel).
- locked goes to 1 on the cycle after the accepted bit that completes confirmation.
- With in_valid=0, all pulse outputs are 0 on the following cycle.
- Counter widths: pos uses $clog2(FRAME_LEN+SYNC_W); good_cnt and miss_cnt use $clog2 of their limit +1. No overflow is possible.

Decomposition:
- Package frame_sync_pkg:
  - state_t enum logic [1:0] {HUNT, VERIFY, LOCKED}.
  - Localparam helpers for counter widths.
- Sub-module sync_matcher (parameters SYNC_W, SYNC_PATTERN; ports clk, rst, in_valid, in, match):
  - Holds sr and produces the combinational match.
- The controller FSM, counters and output registers live in frame_sync_controller.

Test Plan (defaults: SYNC=1011, FRAME_LEN=8, CONFIRM=2, MISS_MAX=2):
1. Assert rst for 2 cycles with random in/in_valid -> all outputs 0 and state_o=0 the cycle after each reset edge.
2. Stream 1011, then 10100101, then 1011, then 00111100, then 1011, with in_valid=1 ->
   - state_o=1 after the first 1011.
   - locked=1 one cycle after the second sync's last bit.
   - 8 payload_valid pulses delivering 0,0,1,1,1,1,0,0.
   - frame_start only on the first of them.
   - No payload output for the 0xA5 frame.
3. In HUNT, send 1,0,1,1,0,1,1 -> hunt hit on bit 4, VERIFY with pos restarted. Then a corrupted sync 1111 at the check -> state_o returns to 0, locked stays 0.
4. While LOCKED, drop in_valid for 3 cycles mid-payload -> no pulses, pos frozen. Payload resumes intact, frame_start unchanged, no misses.
5. While LOCKED:
   - One bad sync (0000) -> locked stays 1; the next frame's payload is delivered.
   - Two consecutive bad syncs -> sync_lost pulses once, locked=0, state_o=0 in the same cycle.
6. Reset asserted during a LOCKED payload bit -> next cycle all outputs 0 and state_o=0. A full 1011/payload/1011 sequence relocks, with the same timing as scenario 2.
